// File: rtl/pixer_frame_capture_if.sv
// Signal bundle for pixer_frame_capture: VGA pins toward the capture block, pixel stream and
// frame status back out. frame_crc is present only when PIXER_CRC_EN is defined.
interface pixer_frame_capture_if;
  logic        hsync;
  logic        vsync;
  logic [1:0]  red;
  logic [1:0]  grn;
  logic [1:0]  blu;
  logic        pix_valid;
  logic [11:0] pix_x;
  logic [10:0] pix_y;
  logic [5:0]  pix_rgb;
  logic [11:0] line_len;
  logic [10:0] frame_lines;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        locked;
`ifdef PIXER_CRC_EN
  logic [15:0] frame_crc;

  modport master (
    output hsync, vsync, red, grn, blu,
    input  pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines,
           frame_done, frame_cnt, locked, frame_crc
  );

  modport slave (
    input  hsync, vsync, red, grn, blu,
    output pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines,
           frame_done, frame_cnt, locked, frame_crc
  );
`else
  modport master (
    output hsync, vsync, red, grn, blu,
    input  pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines,
           frame_done, frame_cnt, locked
  );

  modport slave (
    input  hsync, vsync, red, grn, blu,
    output pix_valid, pix_x, pix_y, pix_rgb, line_len, frame_lines,
           frame_done, frame_cnt, locked
  );
`endif
endinterface

// File: rtl/pixer_frame_capture.sv
// VGA capture: measures line/frame geometry and emits a windowed pixel stream with coordinates.
// Optional macro PIXER_CRC_EN adds frame_crc, a CRC-16-CCITT over each frame's valid pixels.
module pixer_frame_capture #(
  parameter bit SYNC_POL = 1'b0,
  parameter int H_START  = 96,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 32,
  parameter int V_ACTIVE = 480
) (
  input  logic                 clk,
  input  logic                 rst,
  pixer_frame_capture_if.slave bus
);

  localparam logic [11:0] H_LO  = 12'(H_START);
  localparam logic [11:0] H_HI  = 12'(H_START + H_ACTIVE);
  localparam logic [10:0] V_LO  = 11'(V_START);
  localparam logic [10:0] V_HI  = 11'(V_START + V_ACTIVE);
  localparam logic [11:0] H_MAX = 12'hFFF;
  localparam logic [10:0] V_MAX = 11'h7FF;

  logic        s1_hsync;
  logic        s1_vsync;
  logic [5:0]  s1_rgb;
  logic        p1_hsync;
  logic        p1_vsync;

  logic [11:0] hcnt;
  logic [10:0] vcnt;
  logic        h_seen;
  logic        v_seen;
  logic        line_have;
  logic        frame_have;
  logic        line_match;
  logic        frame_match;

  logic        pix_valid_r;
  logic [11:0] pix_x_r;
  logic [10:0] pix_y_r;
  logic [5:0]  pix_rgb_r;
  logic [11:0] line_len_r;
  logic [10:0] frame_lines_r;
  logic        frame_done_r;
  logic [15:0] frame_cnt_r;
  logic        locked_r;

  logic        h_trail;
  logic        v_trail;
  logic [11:0] h_inc;
  logic [11:0] cur_h;
  logic [10:0] cur_v;
  logic [10:0] frame_meas;
  logic        in_window;
  logic        line_latch;
  logic        frame_latch;
  logic        line_match_next;
  logic        frame_match_next;

  // cur_h/cur_v are the coordinates of the sample now sitting in stage 1; hcnt/vcnt hold the previous one.
  always_comb begin
    h_trail          = (p1_hsync == SYNC_POL) && (s1_hsync != SYNC_POL);
    v_trail          = (p1_vsync == SYNC_POL) && (s1_vsync != SYNC_POL);
    h_inc            = (hcnt == H_MAX) ? H_MAX : hcnt + 12'd1;
    cur_h            = h_trail ? 12'd0 : h_inc;
    cur_v            = vcnt;
    if (v_trail) begin
      cur_v = 11'd0;
    end else if (h_trail) begin
      cur_v = (vcnt == V_MAX) ? V_MAX : vcnt + 11'd1;
    end
    frame_meas       = vcnt + 11'd1;
    in_window        = (cur_h >= H_LO) && (cur_h < H_HI) &&
                       (cur_v >= V_LO) && (cur_v < V_HI);
    line_latch       = h_trail && h_seen;
    frame_latch      = v_trail && v_seen;
    line_match_next  = line_latch  ? (line_have  && (h_inc == line_len_r))       : line_match;
    frame_match_next = frame_latch ? (frame_have && (frame_meas == frame_lines_r)) : frame_match;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hsync      <= 1'b0;
      s1_vsync      <= 1'b0;
      s1_rgb        <= 6'd0;
      p1_hsync      <= 1'b0;
      p1_vsync      <= 1'b0;
      hcnt          <= 12'd0;
      vcnt          <= 11'd0;
      h_seen        <= 1'b0;
      v_seen        <= 1'b0;
      line_have     <= 1'b0;
      frame_have    <= 1'b0;
      line_match    <= 1'b0;
      frame_match   <= 1'b0;
      pix_valid_r   <= 1'b0;
      pix_x_r       <= 12'd0;
      pix_y_r       <= 11'd0;
      pix_rgb_r     <= 6'd0;
      line_len_r    <= 12'd0;
      frame_lines_r <= 11'd0;
      frame_done_r  <= 1'b0;
      frame_cnt_r   <= 16'd0;
      locked_r      <= 1'b0;
    end else begin
      s1_hsync    <= bus.hsync;
      s1_vsync    <= bus.vsync;
      s1_rgb      <= {bus.red, bus.grn, bus.blu};
      p1_hsync    <= s1_hsync;
      p1_vsync    <= s1_vsync;
      hcnt        <= cur_h;
      vcnt        <= cur_v;
      line_match  <= line_match_next;
      frame_match <= frame_match_next;
      locked_r    <= line_match_next && frame_match_next;
      pix_valid_r <= in_window;
      if (h_trail) begin
        h_seen <= 1'b1;
      end
      if (v_trail) begin
        v_seen <= 1'b1;
      end
      if (line_latch) begin
        line_len_r <= h_inc;
        line_have  <= 1'b1;
      end
      if (frame_latch) begin
        frame_lines_r <= frame_meas;
        frame_have    <= 1'b1;
        frame_cnt_r   <= frame_cnt_r + 16'd1;
      end
      frame_done_r <= frame_latch;
      // Coordinates and colour hold their last in-window values while outside the window.
      if (in_window) begin
        pix_x_r   <= cur_h - H_LO;
        pix_y_r   <= cur_v - V_LO;
        pix_rgb_r <= s1_rgb;
      end
    end
  end

  assign bus.pix_valid   = pix_valid_r;
  assign bus.pix_x       = pix_x_r;
  assign bus.pix_y       = pix_y_r;
  assign bus.pix_rgb     = pix_rgb_r;
  assign bus.line_len    = line_len_r;
  assign bus.frame_lines = frame_lines_r;
  assign bus.frame_done  = frame_done_r;
  assign bus.frame_cnt   = frame_cnt_r;
  assign bus.locked      = locked_r;

`ifdef PIXER_CRC_EN
  function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) begin
        c = {c[14:0], 1'b0} ^ 16'h1021;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

  // The accumulator is stored inverted so that the all-zero reset state means the 0xFFFF seed.
  logic [15:0] crc_acc_n;
  logic [15:0] frame_crc_r;
  logic [15:0] crc_base;
  logic [15:0] crc_next;

  always_comb begin
    crc_base = frame_latch ? 16'hFFFF : ~crc_acc_n;
    crc_next = crc_base;
    if (in_window) begin
      crc_next = crc_byte(crc_base, {2'b00, s1_rgb});
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_acc_n   <= 16'd0;
      frame_crc_r <= 16'd0;
    end else begin
      crc_acc_n <= ~crc_next;
      if (frame_latch) begin
        frame_crc_r <= ~crc_acc_n;
      end
    end
  end

  assign bus.frame_crc = frame_crc_r;
`endif

endmodule

// File: tb/tb_pixer_frame_capture.sv
// Scoreboard bench for pixer_frame_capture: random VGA-like frames feed a sample-level reference
// model whose expected pixels/frames/status are queued and matched by an independent monitor.
module tb_pixer_frame_capture;

  localparam bit SYNC_POL = 1'b0;
  localparam int HS = 4;
  localparam int HA = 8;
  localparam int VS = 2;
  localparam int VA = 4;

  typedef struct { int stamp; int x; int y; int rgb; } pix_t;
  typedef struct { int stamp; int lines; int cnt; int crc; } frm_t;
  typedef struct { int stamp; int line_len; int frame_lines; int locked; } st_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_pass;
  bit   mon_en;

  pix_t pix_q[$];
  frm_t frm_q[$];
  st_t  st_q[$];

  pixer_frame_capture_if bus ();

  pixer_frame_capture #(
    .SYNC_POL (SYNC_POL),
    .H_START  (HS),
    .H_ACTIVE (HA),
    .V_START  (VS),
    .V_ACTIVE (VA)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: one call per pin sample, in terms of distances between sync trailing edges.
  int   m_idx, m_last_h, m_lines, m_frames, m_crc;
  bit   m_prev_hact, m_prev_vact, m_h_seen, m_v_seen;
  int   line_hist[$];
  int   frm_hist[$];
  logic prev_hs, prev_vs;
  logic [5:0] prev_rgb;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int crcStep(input int crc_in, input int b);
    int c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      int fb;
      fb = ((c >> 15) & 1) ^ ((b >> i) & 1);
      c = (c << 1) & 'hFFFF;
      if (fb != 0) c = c ^ 'h1021;
    end
    return c;
  endfunction

  function automatic bit lastTwoEqual(input int q[$]);
    if (q.size() < 2) return 1'b0;
    return q[q.size()-1] == q[q.size()-2];
  endfunction

  // The capture registers reset to 0, which the model treats as two earlier samples with both syncs at 0.
  task automatic modelReset();
    m_idx       = 0;
    m_last_h    = -1;
    m_lines     = 0;
    m_frames    = 0;
    m_crc       = 'hFFFF;
    m_prev_hact = (SYNC_POL == 1'b0);
    m_prev_vact = (SYNC_POL == 1'b0);
    m_h_seen    = 1'b0;
    m_v_seen    = 1'b0;
    line_hist.delete();
    frm_hist.delete();
    prev_hs  = 1'b0;
    prev_vs  = 1'b0;
    prev_rgb = 6'd0;
  endtask

  task automatic modelStep(input logic hs, input logic vs, input logic [5:0] rgb, input int stamp);
    bit hact, vact, htr, vtr, latched;
    int h, v, ll, fl, locked;
    hact    = (hs == SYNC_POL);
    vact    = (vs == SYNC_POL);
    htr     = m_prev_hact && !hact;
    vtr     = m_prev_vact && !vact;
    latched = 1'b0;
    if (htr) begin
      h = 0;
      if (m_h_seen) begin
        ll = imin(m_idx - m_last_h, 4095);
        line_hist.push_back(ll);
        latched = 1'b1;
      end
      m_h_seen = 1'b1;
      m_last_h = m_idx;
    end else begin
      h = imin(m_idx - m_last_h, 4095);
    end
    if (vtr)      v = 0;
    else if (htr) v = imin(m_lines + 1, 2047);
    else          v = m_lines;
    if (vtr) begin
      if (m_v_seen) begin
        fl = (m_lines + 1) % 2048;
        frm_hist.push_back(fl);
        m_frames = (m_frames + 1) % 65536;
        frm_q.push_back(frm_t'{stamp, fl, m_frames, m_crc});
        m_crc   = 'hFFFF;
        latched = 1'b1;
      end
      m_v_seen = 1'b1;
    end
    m_lines = v;
    if (h >= HS && h < HS + HA && v >= VS && v < VS + VA) begin
      pix_q.push_back(pix_t'{stamp, h - HS, v - VS, int'(rgb)});
      m_crc = crcStep(m_crc, int'(rgb));
    end
    if (latched) begin
      locked = (lastTwoEqual(line_hist) && lastTwoEqual(frm_hist)) ? 1 : 0;
      st_q.push_back(st_t'{stamp,
                           (line_hist.size() > 0) ? line_hist[line_hist.size()-1] : 0,
                           (frm_hist.size() > 0) ? frm_hist[frm_hist.size()-1] : 0,
                           locked});
    end
    m_prev_hact = hact;
    m_prev_vact = vact;
    m_idx++;
  endtask

  // Called at a falling edge: the previously driven sample is the one the next rising edge reports on.
  task automatic applyStimulus(input logic hs, input logic vs, input logic [5:0] rgb);
    modelStep(prev_hs, prev_vs, prev_rgb, cyc + 1);
    bus.hsync = hs;
    bus.vsync = vs;
    {bus.red, bus.grn, bus.blu} = rgb;
    prev_hs  = hs;
    prev_vs  = vs;
    prev_rgb = rgb;
    @(negedge clk);
  endtask

  task automatic sendFrame(input int nlines, input bit vary, input bit pattern, input bit align,
                           input int odd_line, input int odd_len);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = 20;
      if (l == odd_line) len = odd_len;
      else if (vary && $urandom_range(0, 5) == 0) len = 16 + $urandom_range(0, 8);
      for (int c = 0; c < len; c++) begin
        logic hs, vs;
        logic [5:0] rgb;
        hs  = (c < 3) ? SYNC_POL : ~SYNC_POL;
        vs  = ((l < 2) || (align && l == 2 && c < 3)) ? SYNC_POL : ~SYNC_POL;
        rgb = pattern ? 6'(c - 7) : 6'($urandom);
        applyStimulus(hs, vs, rgb);
      end
    end
  endtask

  task automatic checkResetState();
    checkOutput("rst_pix_valid",   int'(bus.pix_valid),   0);
    checkOutput("rst_pix_x",       int'(bus.pix_x),       0);
    checkOutput("rst_pix_y",       int'(bus.pix_y),       0);
    checkOutput("rst_pix_rgb",     int'(bus.pix_rgb),     0);
    checkOutput("rst_line_len",    int'(bus.line_len),    0);
    checkOutput("rst_frame_lines", int'(bus.frame_lines), 0);
    checkOutput("rst_frame_done",  int'(bus.frame_done),  0);
    checkOutput("rst_frame_cnt",   int'(bus.frame_cnt),   0);
    checkOutput("rst_locked",      int'(bus.locked),      0);
`ifdef PIXER_CRC_EN
    checkOutput("rst_frame_crc",   int'(bus.frame_crc),   0);
`endif
  endtask

  task automatic midFrameReset();
    mon_en = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkResetState();
    pix_q.delete();
    frm_q.delete();
    st_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    modelReset();
    mon_en = 1'b1;
  endtask

  initial begin : monitor
    pix_t p;
    frm_t f;
    st_t  s;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && !rst) begin
        while (pix_q.size() > 0 && pix_q[0].stamp < cyc) begin
          checkOutput("pix_valid_missing", 0, 1);
          void'(pix_q.pop_front());
        end
        if (bus.pix_valid) begin
          if (pix_q.size() > 0 && pix_q[0].stamp == cyc) begin
            p = pix_q.pop_front();
            checkOutput("pix_x",   int'(bus.pix_x),   p.x);
            checkOutput("pix_y",   int'(bus.pix_y),   p.y);
            checkOutput("pix_rgb", int'(bus.pix_rgb), p.rgb);
          end else begin
            checkOutput("pix_valid_spurious", 1, 0);
          end
        end
        while (frm_q.size() > 0 && frm_q[0].stamp < cyc) begin
          checkOutput("frame_done_missing", 0, 1);
          void'(frm_q.pop_front());
        end
        if (bus.frame_done) begin
          if (frm_q.size() > 0 && frm_q[0].stamp == cyc) begin
            f = frm_q.pop_front();
            checkOutput("frame_lines_at_done", int'(bus.frame_lines), f.lines);
            checkOutput("frame_cnt",           int'(bus.frame_cnt),   f.cnt);
`ifdef PIXER_CRC_EN
            checkOutput("frame_crc",           int'(bus.frame_crc),   f.crc);
`endif
          end else begin
            checkOutput("frame_done_spurious", 1, 0);
          end
        end
        while (st_q.size() > 0 && st_q[0].stamp < cyc) void'(st_q.pop_front());
        if (st_q.size() > 0 && st_q[0].stamp == cyc) begin
          s = st_q.pop_front();
          checkOutput("line_len",    int'(bus.line_len),    s.line_len);
          checkOutput("frame_lines", int'(bus.frame_lines), s.frame_lines);
          checkOutput("locked",      int'(bus.locked),      s.locked);
        end
      end
    end
  end

  initial begin : stimulus
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    bus.hsync = ~SYNC_POL;
    bus.vsync = ~SYNC_POL;
    bus.red   = 2'd0;
    bus.grn   = 2'd0;
    bus.blu   = 2'd0;
    modelReset();
    repeat (3) @(negedge clk);
    checkResetState();
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 5; i++) sendFrame(12, 1'b0, (i % 2) == 1, i == 3, -1, 0);
    sendFrame(6, 1'b0, 1'b0, 1'b0, -1, 0);
    midFrameReset();

    for (int i = 0; i < 3; i++) sendFrame(12, 1'b0, 1'b1, 1'b0, -1, 0);
    sendFrame(12, 1'b0, 1'b0, 1'b0, 4, 16);
    for (int i = 0; i < 3; i++) sendFrame(12, 1'b0, 1'b0, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) sendFrame(12, 1'b1, 1'b0, $urandom_range(0, 1) == 1, -1, 0);
    sendFrame(12, 1'b0, 1'b0, 1'b0, 5, 4200);
    for (int i = 0; i < 2; i++) sendFrame(12, 1'b0, 1'b1, 1'b0, -1, 0);
    mon_en = 1'b0;

    checkOutput("pix_pending",    pix_q.size(), 0);
    checkOutput("frame_pending",  frm_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixer_frame_capture.md
Name: pixer_frame_capture

Overview:
Synthesizable video capture block that watches the board's VGA output (hsync, vsync, 2-bit R/G/B) on the system clock. It measures line and frame geometry and emits a windowed pixel stream with x/y coordinates and per-frame status. It sits beside the video generator in simulation and debug builds, and is used to check or dump the generated picture.

Parameters:
SYNC_POL, 0, sync polarity: 0 = active-low, 1 = active-high; applies to both syncs
H_START, 96, clocks after hsync trailing edge to first active pixel
H_ACTIVE, 640, active pixels per line
V_START, 32, lines after vsync trailing edge to first active line
V_ACTIVE, 480, active lines per frame

Ports:
clk  in  1  system clock (fclk)
rst  in  1  asynchronous, active-high reset
hsync  in  1  horizontal sync
vsync  in  1  vertical sync
red  in  2  red level
grn  in  2  green level
blu  in  2  blue level
pix_valid  out  1  pixel inside active window this cycle
pix_x  out  12  column within window
pix_y  out  11  row within window
pix_rgb  out  6  {red,grn,blu}
line_len  out  12  clocks between the last two hsync trailing edges
frame_lines  out  11  lines between the last two vsync trailing edges
frame_done  out  1  one-clock pulse at the end of each complete frame
frame_cnt  out  16  number of frame_done pulses since reset, wraps
locked  out  1  geometry stable

Behaviour:
- All outputs and internal state are 0 on rst, asynchronously.
- Stage 1 registers hsync, vsync and rgb each clock. Edge detection uses stage-1 versus previous stage-1 values.
- Trailing edge means the sync goes from active to inactive per SYNC_POL.
- hcnt (12b): loads 0 on the hsync trailing edge, otherwise increments and saturates at 4095.
- vcnt (11b): loads 0 on the vsync trailing edge. Otherwise it increments on each hsync trailing edge and saturates at 2047.
- If both trailing edges occur in the same cycle, vcnt = 0 and hcnt = 0.
- On the hsync trailing edge, line_len <= hcnt + 1, saturating at 4095. The value is latched only after at least one prior hsync trailing edge since reset.
- On the vsync trailing edge, frame_lines <= vcnt + 1. The value is latched only after a prior vsync trailing edge.
- frame_done pulses for one clock on each vsync trailing edge except the first after reset. frame_cnt increments on each pulse and wraps from 0xFFFF to 0.
- Window: H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE.
- Outside the window pix_valid = 0; pix_x, pix_y and pix_rgb hold their last values.
- Inside the window, the stage-2 registers update: pix_valid = 1, pix_x = hcnt - H_START, pix_y = vcnt - V_START, pix_rgb = stage-1 rgb.
- Total latency from pin to pix_* is 2 clocks.
- A pixel sampled in the same cycle as a sync trailing edge counts as hcnt = 0 (or vcnt = 0).
- Sync held active does not stop counting. An active sync inside the window does not mask pix_valid.
- locked = 1 when the last two latched line_len values are equal and the last two latched frame_lines values are equal. It drops in the cycle after any mismatching latch.
- Reset mid-frame: all counters restart, and the first-edge rules apply again.

Optional Feature:
PIXER_CRC_EN.
- When defined, adds output frame_crc (16b) containing the CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no reflection, no xorout) of every pix_valid byte {2'b00, pix_rgb} in the frame.
- At frame_done, frame_crc latches the accumulator and the accumulator reinitialises to 0xFFFF in the same cycle.
- Pixels valid in that same cycle seed the new frame.
- When the macro is not defined, the port and its logic are absent.

Test Plan:
- Reset: rst=1 asynchronously mid-clock -> all outputs 0 immediately; frame_done stays 0 at the first vsync trailing edge after release.
- Line timing: hsync active-low, 96-clock pulse, 896-clock period -> from the second line, line_len = 896. pix_valid rises 2 clocks after the hcnt=96 sample, with pix_x = 0..639, then falls.
- Frame timing: 525-line frames -> frame_lines = 525; frame_done pulses once per frame from frame 2; frame_cnt = 1, 2, 3; locked = 1 after the third line and second frame.
- Geometry change: shorten one line to 800 clocks -> line_len = 800, locked drops to 0; restored to 896 -> locked returns after two matching lines.
- Pixel data: rgb = pix_x[5:0] pattern -> pix_rgb equals pix_x[5:0] at each valid cycle; pix_y = 0 on line V_START and 479 on the last active line.
- PIXER_CRC_EN: all-zero-rgb 640x480 frame -> frame_crc equals the CCITT CRC of 307200 zero bytes; a single pixel flipped to 6'h3F -> different frame_crc.
